// File: rtl/batcharger_adc_seq_if.sv
// Charger-controller <-> ADC sequencer bus: channel enables, shared SAR ADC
// handshake and the latched measurement results.
interface batcharger_adc_seq_if;
  logic       en;
  logic       vmonen;
  logic       imonen;
  logic       tmonen;
  logic [1:0] adc_sel;
  logic       adc_start;
  logic       adc_done;
  logic [7:0] adc_data;
  logic [7:0] vbat;
  logic [7:0] ibat;
  logic [7:0] tbat;
  logic       vtok;
  logic       adc_err;

  modport master (
    output en, vmonen, imonen, tmonen, adc_done, adc_data,
    input  adc_sel, adc_start, vbat, ibat, tbat, vtok, adc_err
  );

  modport slave (
    input  en, vmonen, imonen, tmonen, adc_done, adc_data,
    output adc_sel, adc_start, vbat, ibat, tbat, vtok, adc_err
  );
endinterface

// File: rtl/batcharger_adc_seq.sv
// Round-robin V/I/T sequencer for a shared SAR ADC: mux settle, start pulse,
// bounded wait for done, per-channel result latch and freshness flag.
module batcharger_adc_seq #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  batcharger_adc_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, START, CONV} state_t;

  state_t     state;
  logic [3:0] settle_cnt;
  logic [7:0] tmo_cnt;
  logic       vv, tv;
  logic       drop;
  logic [2:0] ch_en;
  logic [2:0] nxt_idle, nxt_conv;

  assign ch_en = {bus.tmonen, bus.imonen, bus.vmonen};

  // Next enabled channel after cur in V->I->T->V order; bit 2 = found.
  function automatic logic [2:0] pick(input logic [1:0] cur, input logic [2:0] ens);
    logic [1:0] c;
    pick = 3'b000;
    c    = cur;
    for (int i = 0; i < 3; i++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (ens[c] && !pick[2]) pick = {1'b1, c};
    end
  endfunction

  assign nxt_idle = pick(2'd2, ch_en);
  assign nxt_conv = pick(bus.adc_sel, ch_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.adc_sel   <= 2'b00;
      bus.adc_start <= 1'b0;
      bus.vbat      <= 8'h00;
      bus.ibat      <= 8'h00;
      bus.tbat      <= 8'h00;
      bus.vtok      <= 1'b0;
      bus.adc_err   <= 1'b0;
      vv            <= 1'b0;
      tv            <= 1'b0;
      drop          <= 1'b0;
      settle_cnt    <= 4'd0;
      tmo_cnt       <= 8'd0;
    end else if (!bus.en) begin
      state         <= IDLE;
      bus.adc_start <= 1'b0;
      bus.vtok      <= 1'b0;
      bus.adc_err   <= 1'b0;
      vv            <= 1'b0;
      tv            <= 1'b0;
      drop          <= 1'b0;
      settle_cnt    <= 4'd0;
      tmo_cnt       <= 8'd0;
    end else begin
      bus.adc_start <= 1'b0;
      bus.vtok      <= vv & tv & ~bus.adc_err;
      if (!bus.vmonen) vv <= 1'b0;
      if (!bus.tmonen) tv <= 1'b0;
      // A channel disabled at any point of its slot loses this result.
      if (state != IDLE && !ch_en[bus.adc_sel]) drop <= 1'b1;
      case (state)
        IDLE: begin
          if (nxt_idle[2]) begin
            bus.adc_sel <= nxt_idle[1:0];
            settle_cnt  <= 4'd0;
            drop        <= 1'b0;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'(SETTLE_CYC - 1)) begin
            bus.adc_start <= 1'b1;
            state         <= START;
          end else if (settle_cnt != 4'hF) begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        START: begin
          tmo_cnt <= 8'd0;
          state   <= CONV;
        end
        CONV: begin
          // done wins over a timeout expiring in the same cycle
          if (bus.adc_done || tmo_cnt == 8'(TIMEOUT_CYC - 1)) begin
            if (bus.adc_done && !drop && ch_en[bus.adc_sel]) begin
              case (bus.adc_sel)
                2'd0:    begin bus.vbat <= bus.adc_data; vv <= 1'b1; end
                2'd1:    bus.ibat <= bus.adc_data;
                default: begin bus.tbat <= bus.adc_data; tv <= 1'b1; end
              endcase
            end
            if (!bus.adc_done) bus.adc_err <= 1'b1;
            if (nxt_conv[2]) begin
              bus.adc_sel <= nxt_conv[1:0];
              settle_cnt  <= 4'd0;
              drop        <= 1'b0;
              state       <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end else if (tmo_cnt != 8'hFF) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_batcharger_adc_seq.sv
// Directed bench for batcharger_adc_seq with a behavioural ADC that answers
// a fixed number of cycles after each start pulse.
module tb_batcharger_adc_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  batcharger_adc_seq_if ifc();
  batcharger_adc_seq dut (.clk(clk), .rst(rst), .bus(ifc));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // ADC model: per-channel latency (0 = never answers) and value
  int         m_dly [3];
  logic [7:0] m_val [3];
  int         m_cnt  = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       s_done = 1'b0;
  logic [7:0] s_data = 8'h00;
  assign ifc.adc_done = m_done | s_done;
  assign ifc.adc_data = m_done ? m_data : s_data;

  always @(negedge clk) begin
    m_done = 1'b0;
    if (ifc.adc_start === 1'b1) begin
      m_cnt  = m_dly[int'(ifc.adc_sel)];
      m_data = m_val[int'(ifc.adc_sel)];
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_done = 1'b1;
    end
  end

  int         st_cyc [$];
  logic [1:0] st_sel [$];
  always @(negedge clk)
    if (ifc.adc_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_sel.push_back(ifc.adc_sel);
    end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (st_cyc.size() >= n) ok = 1'b1;
      else tick();
    end
    if (st_cyc.size() >= n) ok = 1'b1;
  endtask

  task automatic seq_off();
    ifc.en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_en(input logic v, input logic i, input logic t);
    ifc.vmonen = v;
    ifc.imonen = i;
    ifc.tmonen = t;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (ifc.adc_sel !== 2'b00) begin errors++; $display("FAIL rst_sel got %b want 00", ifc.adc_sel); end
    checks++; if (ifc.adc_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", ifc.adc_start); end
    checks++; if (ifc.vbat !== 8'h00) begin errors++; $display("FAIL rst_vbat got %h want 00", ifc.vbat); end
    checks++; if (ifc.ibat !== 8'h00) begin errors++; $display("FAIL rst_ibat got %h want 00", ifc.ibat); end
    checks++; if (ifc.tbat !== 8'h00) begin errors++; $display("FAIL rst_tbat got %h want 00", ifc.tbat); end
    checks++; if (ifc.vtok !== 1'b0) begin errors++; $display("FAIL rst_vtok got %b want 0", ifc.vtok); end
    checks++; if (ifc.adc_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", ifc.adc_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_all_channels();
    int n0;
    bit ok;
    logic [1:0] exp_sel [4];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
    m_dly = '{10, 10, 10};
    m_val = '{8'hB4, 8'h40, 8'h70};
    n0 = st_cyc.size();
    set_en(1, 1, 1);
    ifc.en = 1'b1;
    wait_starts(n0 + 3, 200, ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ifc.tbat === 8'h70) ok = 1'b1;
      else tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL all_tload got tbat=%h want 70", ifc.tbat); end
    checks++; if (ifc.vtok !== 1'b0) begin errors++; $display("FAIL all_vtok_early got %b want 0", ifc.vtok); end
    tick();
    checks++; if (ifc.vtok !== 1'b1) begin errors++; $display("FAIL all_vtok_rise got %b want 1", ifc.vtok); end
    wait_starts(n0 + 4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL all_starts got %0d want %0d", st_cyc.size() - n0, 4); end
    if (ok)
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (st_sel[n0 + i] !== exp_sel[i]) begin
          errors++; $display("FAIL all_sel%0d got %b want %b", i, st_sel[n0 + i], exp_sel[i]);
        end
      end
    checks++; if (ifc.vbat !== 8'hB4) begin errors++; $display("FAIL all_vbat got %h want b4", ifc.vbat); end
    checks++; if (ifc.ibat !== 8'h40) begin errors++; $display("FAIL all_ibat got %h want 40", ifc.ibat); end
    checks++; if (ifc.tbat !== 8'h70) begin errors++; $display("FAIL all_tbat got %h want 70", ifc.tbat); end
  endtask

  task automatic test_only_v();
    int n0;
    bit ok;
    bit vt;
    bit badsel;
    seq_off();
    set_en(1, 0, 0);
    m_val[0] = 8'hC3;
    n0 = st_cyc.size();
    ifc.en = 1'b1;
    vt = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 120 && !ok; i++) begin
      if (ifc.vtok !== 1'b0) vt = 1'b1;
      if (st_cyc.size() >= n0 + 3) ok = 1'b1;
      else tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL onlyv_starts got %0d want 3", st_cyc.size() - n0); end
    if (ok) begin
      checks++; if (st_cyc[n0 + 1] - st_cyc[n0] != 15) begin errors++; $display("FAIL onlyv_gap1 got %0d want 15", st_cyc[n0 + 1] - st_cyc[n0]); end
      checks++; if (st_cyc[n0 + 2] - st_cyc[n0 + 1] != 15) begin errors++; $display("FAIL onlyv_gap2 got %0d want 15", st_cyc[n0 + 2] - st_cyc[n0 + 1]); end
      badsel = 1'b0;
      for (int i = 0; i < 3; i++) if (st_sel[n0 + i] !== 2'd0) badsel = 1'b1;
      checks++; if (badsel) begin errors++; $display("FAIL onlyv_sel got non-00 want 00"); end
    end
    checks++; if (vt) begin errors++; $display("FAIL onlyv_vtok got 1 want 0"); end
    checks++; if (ifc.vbat !== 8'hC3) begin errors++; $display("FAIL onlyv_vbat got %h want c3", ifc.vbat); end
  endtask

  task automatic test_timeout();
    int n0;
    int ecyc;
    bit ok;
    seq_off();
    set_en(1, 1, 1);
    m_dly = '{10, 0, 10};
    m_val = '{8'h11, 8'h99, 8'h22};
    n0 = st_cyc.size();
    ifc.en = 1'b1;
    wait_starts(n0 + 2, 100, ok);
    ecyc = -1;
    for (int i = 0; i < 100 && ecyc < 0; i++) begin
      if (ifc.adc_err === 1'b1) ecyc = cyc;
      else tick();
    end
    checks++;
    if (!ok || ecyc - st_cyc[n0 + 1] != 65) begin
      errors++; $display("FAIL tmo_delay got %0d want 65", ecyc - st_cyc[n0 + 1]);
    end
    checks++; if (ifc.ibat !== 8'h40) begin errors++; $display("FAIL tmo_ibat got %h want 40", ifc.ibat); end
    wait_starts(n0 + 3, 20, ok);
    checks++; if (!ok || st_sel[n0 + 2] !== 2'd2) begin errors++; $display("FAIL tmo_next got %b want 10", st_sel[n0 + 2]); end
    repeat (14) tick();
    checks++; if (ifc.tbat !== 8'h22) begin errors++; $display("FAIL tmo_tbat got %h want 22", ifc.tbat); end
    checks++; if (ifc.vtok !== 1'b0) begin errors++; $display("FAIL tmo_vtok got %b want 0", ifc.vtok); end
    checks++; if (ifc.adc_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", ifc.adc_err); end
  endtask

  task automatic test_coincident();
    int n0;
    bit ok;
    seq_off();
    set_en(1, 1, 1);
    m_dly = '{10, 64, 10};
    m_val = '{8'h11, 8'h5A, 8'h22};
    n0 = st_cyc.size();
    ifc.en = 1'b1;
    wait_starts(n0 + 3, 200, ok);
    checks++; if (!ok || st_sel[n0 + 2] !== 2'd2) begin errors++; $display("FAIL coin_next got %b want 10", st_sel[n0 + 2]); end
    checks++; if (ifc.ibat !== 8'h5A) begin errors++; $display("FAIL coin_ibat got %h want 5a", ifc.ibat); end
    checks++; if (ifc.adc_err !== 1'b0) begin errors++; $display("FAIL coin_err got %b want 0", ifc.adc_err); end
  endtask

  task automatic test_en_abort();
    int n0;
    int n1;
    bit ok;
    seq_off();
    set_en(1, 1, 1);
    m_dly = '{10, 10, 10};
    m_val = '{8'h31, 8'h32, 8'h33};
    n0 = st_cyc.size();
    ifc.en = 1'b1;
    wait_starts(n0 + 3, 100, ok);
    m_val[0] = 8'h3F;
    wait_starts(n0 + 4, 40, ok);
    checks++; if (!ok || ifc.vtok !== 1'b1) begin errors++; $display("FAIL abort_pre_vtok got %b want 1", ifc.vtok); end
    repeat (3) tick();
    ifc.en = 1'b0;
    tick();
    checks++; if (ifc.adc_start !== 1'b0) begin errors++; $display("FAIL abort_start got %b want 0", ifc.adc_start); end
    checks++; if (ifc.vtok !== 1'b0) begin errors++; $display("FAIL abort_vtok got %b want 0", ifc.vtok); end
    checks++; if (ifc.adc_err !== 1'b0) begin errors++; $display("FAIL abort_err got %b want 0", ifc.adc_err); end
    repeat (12) tick();
    checks++; if (ifc.vbat !== 8'h31) begin errors++; $display("FAIL abort_vbat got %h want 31", ifc.vbat); end
    checks++; if (ifc.ibat !== 8'h32) begin errors++; $display("FAIL abort_ibat got %h want 32", ifc.ibat); end
    checks++; if (ifc.tbat !== 8'h33) begin errors++; $display("FAIL abort_tbat got %h want 33", ifc.tbat); end
    checks++; if (st_cyc.size() != n0 + 4) begin errors++; $display("FAIL abort_idle got %0d starts want %0d", st_cyc.size(), n0 + 4); end
    n1 = st_cyc.size();
    ifc.en = 1'b1;
    wait_starts(n1 + 1, 20, ok);
    checks++; if (!ok || st_sel[n1] !== 2'd0) begin errors++; $display("FAIL abort_restart got %b want 00", st_sel[n1]); end
  endtask

  task automatic test_rst_settle();
    seq_off();
    set_en(1, 1, 1);
    ifc.en = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (ifc.adc_sel !== 2'b00) begin errors++; $display("FAIL arst_sel got %b want 00", ifc.adc_sel); end
    checks++; if (ifc.adc_start !== 1'b0) begin errors++; $display("FAIL arst_start got %b want 0", ifc.adc_start); end
    checks++; if (ifc.vbat !== 8'h00) begin errors++; $display("FAIL arst_vbat got %h want 00", ifc.vbat); end
    checks++; if (ifc.ibat !== 8'h00) begin errors++; $display("FAIL arst_ibat got %h want 00", ifc.ibat); end
    checks++; if (ifc.tbat !== 8'h00) begin errors++; $display("FAIL arst_tbat got %h want 00", ifc.tbat); end
    checks++; if (ifc.vtok !== 1'b0) begin errors++; $display("FAIL arst_vtok got %b want 0", ifc.vtok); end
    #2 rst = 1'b0;
    tick();
    s_data = 8'hEE;
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    tick();
    checks++; if (ifc.vbat !== 8'h00) begin errors++; $display("FAIL arst_stray got %h want 00", ifc.vbat); end
    checks++; if (ifc.adc_err !== 1'b0) begin errors++; $display("FAIL arst_err got %b want 0", ifc.adc_err); end
  endtask

  initial begin
    rst = 1'b1;
    ifc.en = 1'b0;
    set_en(0, 0, 0);
    m_dly = '{10, 10, 10};
    m_val = '{8'h00, 8'h00, 8'h00};
    #12;
    test_reset();
    test_all_channels();
    test_only_v();
    test_timeout();
    test_coincident();
    test_en_abort();
    test_rst_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
